i2c_master: RTL and testbench

//  Byte-level I2C master engine downstream of the NES controller bridge sequencer: accepts START/WRITE/READ/STOP

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_quarter_tick.sv | 30 +++
 rtl/i2c_master.sv | 189 ++++++++++++++++++
 tb/tb_i2c_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the byte-level I2C master: command opcodes and FSM states.
package i2c_pkg;

  typedef enum logic [1:0] {
    I2C_START = 2'd0,
    I2C_WRITE = 2'd1,
    I2C_READ  = 2'd2,
    I2C_STOP  = 2'd3
  } i2c_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } i2c_state_e;

  localparam logic [1:0] Q_SAMPLE = 2'd1;  // quarter whose final cycle samples SDA
  localparam logic [1:0] Q_LAST   = 2'd3;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-phase divider: down-counter that pulses tick_o once every CLK_DIV cycles,
// restarting a full quarter whenever clr_i is asserted.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || cnt_q == '0) cnt_d = RELOAD;
    else                      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= RELOAD;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master: START/WRITE/READ/STOP commands over valid/ready, registered
// SCL/SDA drive, read data and ACK status returned with a one-cycle rsp_valid pulse.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       bus_owned,
  output logic       scl_out,
  input  logic       sda_in,
  output logic       sda_out
);

  i2c_state_e state_q, state_d;
  i2c_op_e    op_q, op_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  logic       nack_q, nack_d, nak_q, nak_d;
  logic       cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_nack_q, rsp_nack_d, owned_q, owned_d;
  logic       scl_q, scl_d, sda_q, sda_d;
  logic       accept, tick;

  assign accept = cmd_valid && cmd_ready_q;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    nack_d      = nack_q;
    nak_d       = nak_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;
    owned_d     = owned_q;
    scl_d       = scl_q;
    sda_d       = sda_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          op_d        = i2c_op_e'(cmd_op);
          tx_d        = cmd_data;
          nack_d      = cmd_nack;
          nak_d       = 1'b0;
          phase_d     = 2'd0;
          bit_d       = 3'd7;
          unique case (i2c_op_e'(cmd_op))
            I2C_START: state_d = ST_START;
            I2C_WRITE, I2C_READ: begin
              // Data transfers need an owned bus; otherwise reject without touching the pins.
              if (owned_q) state_d = ST_DATA;
              else begin
                state_d = ST_DONE;
                nak_d   = 1'b1;
              end
            end
            I2C_STOP: state_d = owned_q ? ST_STOP : ST_DONE;
            default:  state_d = ST_DONE;
          endcase
        end
      end
      ST_START, ST_STOP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == Q_LAST) state_d = ST_DONE;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (phase_q == Q_SAMPLE && op_q == I2C_READ) rx_d = {rx_q[6:0], sda_in};
          phase_d = phase_q + 2'd1;
          if (phase_q == Q_LAST) begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          if (phase_q == Q_SAMPLE && op_q == I2C_WRITE) nak_d = sda_in;
          phase_d = phase_q + 2'd1;
          if (phase_q == Q_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        cmd_ready_d = 1'b1;
        rsp_nack_d  = nak_q;
        if (op_q == I2C_READ && !nak_q) rsp_data_d = rx_q;
        if (op_q == I2C_START) owned_d = 1'b1;
        if (op_q == I2C_STOP)  owned_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels follow the upcoming state/quarter; IDLE and DONE hold the last levels.
    case (state_d)
      ST_START: begin
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_d = (phase_d < 2'd2);
      end
      ST_DATA: begin
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_d = (op_d == I2C_READ) ? 1'b1 : tx_d[7];
      end
      ST_ACK: begin
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_d = (op_d == I2C_READ) ? nack_d : 1'b1;
      end
      ST_STOP: begin
        scl_d = (phase_d != 2'd0);
        sda_d = (phase_d >= 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= I2C_START;
      phase_q     <= 2'd0;
      bit_q       <= 3'd7;
      tx_q        <= 8'h00;
      rx_q        <= 8'h00;
      nack_q      <= 1'b0;
      nak_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
      owned_q     <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      nack_q      <= nack_d;
      nak_q       <= nak_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      owned_q     <= owned_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign bus_owned = owned_q;
  assign scl_out   = scl_q;
  assign sda_out   = sda_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master (CLK_DIV=4) with a small open-drain slave model on the bus.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int DIV = 4;
  localparam int LAT_SS = 4 * DIV + 1;
  localparam int LAT_RW = 36 * DIV + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic cmd_nack = 1'b0;
  logic rsp_valid;
  logic [7:0] rsp_data;
  logic rsp_nack;
  logic bus_owned;
  logic scl_out;
  logic sda_out;
  logic sda_line;

  // slave model state
  logic slave_rd = 1'b0;
  logic slave_ack = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic slave_sda;
  int bitcnt = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  int starts = 0;
  int stops = 0;
  logic [7:0] cap = 8'h00;
  logic ack_seen = 1'b1;

  int n_total = 0;
  int n_bad = 0;
  int lat;

  i2c_master #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_nack  (cmd_nack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .bus_owned (bus_owned),
    .scl_out   (scl_out),
    .sda_in    (sda_line),
    .sda_out   (sda_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    slave_sda = 1'b1;
    if (slave_rd && bitcnt >= 0 && bitcnt < 8) slave_sda = slave_byte[3'(7 - bitcnt)];
    else if (!slave_rd && slave_ack && bitcnt == 8) slave_sda = 1'b0;
  end

  assign sda_line = sda_out & slave_sda;

  // Bus watcher: START/STOP detection, bit counting on SCL falls, capture on SCL rises.
  always @(posedge clk) begin
    prev_scl <= scl_out;
    prev_sda <= sda_line;
    if (prev_scl && scl_out && prev_sda && !sda_line) begin
      starts <= starts + 1;
      bitcnt <= -1;
    end else if (prev_scl && scl_out && !prev_sda && sda_line) begin
      stops <= stops + 1;
    end else if (prev_scl && !scl_out) begin
      bitcnt <= (bitcnt >= 8) ? 0 : bitcnt + 1;
    end else if (!prev_scl && scl_out) begin
      if (bitcnt >= 0 && bitcnt < 8) cap <= {cap[6:0], sda_line};
      if (bitcnt == 8) ack_seen <= sda_line;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic accept_cmd(input logic [1:0] op, input logic [7:0] d, input logic nk);
    int w;
    w = 0;
    @(negedge clk);
    cmd_op = op;
    cmd_data = d;
    cmd_nack = nk;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    // scramble inputs to show they were captured at acceptance
    cmd_valid = 1'b0;
    cmd_data = ~d;
    cmd_nack = ~nk;
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!rsp_valid && l < 2000);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic nk, output int l);
    accept_cmd(op, d, nk);
    wait_rsp(l);
    $display("cmd op=%0d data=%02h nack=%0b -> lat=%0d rsp_data=%02h rsp_nack=%0b owned=%0b",
             op, d, nk, l, rsp_data, rsp_nack, bus_owned);
  endtask

  initial begin
    logic [1:0] ops [4];
    int pulses;
    int w;
    ops[0] = I2C_START; ops[1] = I2C_WRITE; ops[2] = I2C_READ; ops[3] = I2C_STOP;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl_out, 1);
    chk("rst_sda", sda_out, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_nack", rsp_nack, 0);
    chk("rst_owned", bus_owned, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // commands without an owned bus
    run_cmd(I2C_WRITE, 8'h55, 1'b0, lat);
    chk("rej_lat", lat, 1);
    chk("rej_nack", rsp_nack, 1);
    chk("rej_scl", scl_out, 1);
    chk("rej_sda", sda_out, 1);
    run_cmd(I2C_STOP, 8'h00, 1'b0, lat);
    chk("stop_idle_lat", lat, 1);
    chk("stop_idle_nack", rsp_nack, 0);
    chk("stop_idle_stops", stops, 0);

    // START, WRITE 0xA4 acked, WRITE 0x40 unacked, STOP
    run_cmd(I2C_START, 8'h00, 1'b0, lat);
    chk("start_lat", lat, LAT_SS);
    chk("start_owned", bus_owned, 1);
    chk("start_seen", starts, 1);
    chk("start_pins", {scl_out, sda_out}, 2'b00);
    slave_ack = 1'b1;
    run_cmd(I2C_WRITE, 8'hA4, 1'b0, lat);
    chk("wr_lat", lat, LAT_RW);
    chk("wr_nack", rsp_nack, 0);
    chk("wr_bits", cap, 8'hA4);
    chk("wr_no_glitch", {starts, stops}, {32'd1, 32'd0});
    slave_ack = 1'b0;
    run_cmd(I2C_WRITE, 8'h40, 1'b0, lat);
    chk("wr_noack_nack", rsp_nack, 1);
    chk("wr_noack_bits", cap, 8'h40);
    chk("wr_noack_owned", bus_owned, 1);
    run_cmd(I2C_STOP, 8'h00, 1'b0, lat);
    chk("stop_lat", lat, LAT_SS);
    chk("stop_seen", stops, 1);
    chk("stop_owned", bus_owned, 0);
    chk("stop_pins", {scl_out, sda_out}, 2'b11);

    // reads
    run_cmd(I2C_START, 8'h00, 1'b0, lat);
    slave_rd = 1'b1;
    slave_byte = 8'h5A;
    run_cmd(I2C_READ, 8'h00, 1'b1, lat);
    chk("rd1_lat", lat, LAT_RW);
    chk("rd1_data", rsp_data, 8'h5A);
    chk("rd1_ackslot", ack_seen, 1);
    slave_byte = 8'h96;
    run_cmd(I2C_READ, 8'h00, 1'b0, lat);
    chk("rd0_data", rsp_data, 8'h96);
    chk("rd0_ackslot", ack_seen, 0);
    chk("rd0_nack", rsp_nack, 0);
    slave_rd = 1'b0;

    // reset in the middle of a WRITE
    accept_cmd(I2C_WRITE, 8'hF0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_pins", {scl_out, sda_out}, 2'b11);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_owned", bus_owned, 0);
    pulses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("mid_rst_no_rsp", pulses, 0);

    // back-to-back START, WRITE, READ, STOP with cmd_valid held high
    slave_ack = 1'b1;
    slave_byte = 8'hC3;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = ops[0];
    cmd_data = 8'h3C;
    cmd_nack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!cmd_ready && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (i > 0) chk("b2b_no_gap", rsp_valid, 1);
      if (i == 1) chk("b2b_owned", bus_owned, 1);
      if (i == 2) chk("b2b_wr", {rsp_nack, cap}, {1'b0, 8'h3C});
      if (i == 3) chk("b2b_rd", rsp_data, 8'hC3);
      $display("b2b accept op=%0d after %0d waits", ops[i], w);
      @(posedge clk);
      #1;
      if (i == 2) slave_rd = 1'b1;
      if (i == 3) slave_rd = 1'b0;
      if (i < 3) cmd_op = ops[i + 1];
      else cmd_valid = 1'b0;
    end
    wait_rsp(lat);
    chk("b2b_stop_lat", lat, LAT_SS);
    chk("b2b_stop_owned", bus_owned, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
